alu_share_arbiter: RTL

- Shares the single combinational ALU of the multicycle core between NUM_REQ requesters, e.g. PC increment, branch compare and address/execute.
- Each request is arbitrated round-robin, its opcode and operands are registered, the ALU is driven from those registers, and the captured result and zero flag are returned to the granted requester with a one-cycle valid pulse.
- One transaction is in flight at a time. Sustained throughput is one operation per 2 cycles.

---
 rtl/alu_share_arbiter_pkg.sv | 21 ++
 rtl/alu_share_arbiter_rr_priority_picker.sv | 31 +++
 rtl/alu_share_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: ALU opcodes, enables, arbiter state encodings.
package alu_share_arbiter_pkg;

    localparam int unsigned ALU_OP_W = 3;

    // ALU opcode encodings; 3'b111 and the remaining codes are undefined
    localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b100;
    localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b110;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Arbiter state encodings
    localparam logic [1:0] ARB_IDLE  = 2'b00;
    localparam logic [1:0] ARB_ISSUE = 2'b01;
    localparam logic [1:0] ARB_RESP  = 2'b10;

endpackage

// File: rtl/alu_share_arbiter_rr_priority_picker.sv
// Round-robin priority picker: first set request scanning upward from ptr+1 with wrap-around.
module rr_priority_picker #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    int unsigned cand;

    // Scan candidates ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first requester found wins
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = (32'(ptr) + i) % NUM_REQ;
            if (!any && req[IDX_W'(cand)]) begin
                any                 = 1'b1;
                grant[IDX_W'(cand)] = 1'b1;
                idx                 = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters, one transaction in flight at a time.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OP_WIDTH   = 3
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*OP_WIDTH-1:0]    req_op,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_result,
    output logic                           rsp_zero,
    output logic                           rsp_illegal,
    output logic [OP_WIDTH-1:0]            alu_operation,
    output logic [DATA_WIDTH-1:0]          alu_operand_1,
    output logic [DATA_WIDTH-1:0]          alu_operand_2,
    input  logic [DATA_WIDTH-1:0]          alu_result,
    input  logic                           alu_zero,
    output logic                           busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [1:0]          state, state_nxt;
    logic [IDX_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]    grant_idx;
    logic                illegal_q;

    logic                arb_en;
    logic [NUM_REQ-1:0]  pick_grant;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [OP_WIDTH-1:0] op_sel;
    logic                op_legal;

    // Arbitration is only open while no operation occupies the ALU
    assign arb_en = (state == ARB_IDLE) || (state == ARB_RESP);

    rr_priority_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req_valid & {NUM_REQ{arb_en}}),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign req_ready = pick_grant;

    // Select the winner's opcode and classify it before it is latched
    always_comb begin
        op_sel   = req_op[pick_idx*OP_WIDTH +: OP_WIDTH];
        op_legal = (op_sel == OP_WIDTH'(ALU_AND)) || (op_sel == OP_WIDTH'(ALU_OR))  ||
                   (op_sel == OP_WIDTH'(ALU_XOR)) || (op_sel == OP_WIDTH'(ALU_ADD)) ||
                   (op_sel == OP_WIDTH'(ALU_SUB));
    end

    // Next-state: a handshake always launches ISSUE, ISSUE always moves to RESP
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_any) state_nxt = ARB_ISSUE;
            ARB_ISSUE: state_nxt = ARB_RESP;
            ARB_RESP:  state_nxt = pick_any ? ARB_ISSUE : ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // State, pointer, ALU input registers and captured response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ARB_IDLE;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            grant_idx     <= '0;
            illegal_q     <= DISABLE;
            alu_operation <= OP_WIDTH'(ALU_ADD);
            alu_operand_1 <= '0;
            alu_operand_2 <= '0;
            rsp_result    <= '0;
            rsp_zero      <= 1'b0;
            rsp_illegal   <= 1'b0;
            rsp_valid     <= '0;
            busy          <= 1'b0;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != ARB_IDLE);
            rsp_valid <= '0;
            if (pick_any) begin
                rr_ptr        <= pick_idx;
                grant_idx     <= pick_idx;
                illegal_q     <= !op_legal;
                alu_operation <= op_legal ? op_sel : OP_WIDTH'(ALU_ADD);
                alu_operand_1 <= req_a[pick_idx*DATA_WIDTH +: DATA_WIDTH];
                alu_operand_2 <= req_b[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (state == ARB_ISSUE) begin
                rsp_result  <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_illegal <= illegal_q;
                rsp_valid   <= NUM_REQ'(1) << grant_idx;
            end
        end
    end

endmodule
